// File: rtl/multdiv_unit_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
package multdiv_unit_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int CNT_W_DEFAULT = 6;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/multdiv_datapath.sv
// Iterative datapath: radix-2 Booth multiply and restoring divide, one bit per cycle.
module multdiv_datapath
  import multdiv_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic               load_div,
  input  logic               step_mul,
  input  logic               step_div,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  output logic [CNT_W-1:0]   count,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient
);

  // acc doubles as the Booth accumulator and the divide remainder; q holds the
  // multiplier (mul) or the dividend bits shifting out / quotient bits shifting in (div).
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   mcand;
  logic [WIDTH-1:0] q;
  logic             q_m1;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

  always_comb begin
    mag_a     = operand_a[WIDTH-1] ? -operand_a : operand_a;
    mag_b     = operand_b[WIDTH-1] ? -operand_b : operand_b;
    booth_sum = acc;
    case ({q[0], q_m1})
      2'b01:   booth_sum = acc + mcand;
      2'b10:   booth_sum = acc - mcand;
      default: booth_sum = acc;
    endcase
    div_shift = {acc[WIDTH-1:0], q[WIDTH-1]};
    div_diff  = div_shift - mcand;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc   <= '0;
      mcand <= '0;
      q     <= '0;
      q_m1  <= 1'b0;
      count <= '0;
    end else if (load) begin
      acc   <= '0;
      q_m1  <= 1'b0;
      count <= '0;
      if (load_div) begin
        q     <= mag_a;
        mcand <= {1'b0, mag_b};
      end else begin
        q     <= operand_b;
        mcand <= {operand_a[WIDTH-1], operand_a};
      end
    end else if (step_mul) begin
      acc   <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      q     <= {booth_sum[0], q[WIDTH-1:1]};
      q_m1  <= q[0];
      count <= count + CNT_W'(1);
    end else if (step_div) begin
      // A negative trial difference means the divisor did not fit: keep the shifted remainder.
      if (!div_diff[WIDTH]) begin
        acc <= div_diff;
        q   <= {q[WIDTH-2:0], 1'b1};
      end else begin
        acc <= div_shift;
        q   <= {q[WIDTH-2:0], 1'b0};
      end
      count <= count + CNT_W'(1);
    end
  end

  assign product  = {acc[WIDTH-1:0], q};
  assign quotient = q;

endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply/divide unit: FSM, start/abort arbitration, exceptions, output registers.
module multdiv_unit
  import multdiv_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_t state;

  logic               start;
  logic               iter_done;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quotient;

  logic sign_diff;
  logic div_zero;
  logic div_ovf;

  logic             mul_overflow;
  logic [WIDTH-1:0] div_result;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign iter_done = (count == CNT_W'(WIDTH));

  multdiv_datapath #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_datapath (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (start),
    .load_div  (!ctrl_MULT),
    .step_mul  ((state == MUL) && !iter_done),
    .step_div  ((state == DIV) && !iter_done),
    .operand_a (data_operandA),
    .operand_b (data_operandB),
    .count     (count),
    .product   (product),
    .quotient  (quotient)
  );

  // INT_MIN / -1 needs no special data path: its unsigned quotient already reads as INT_MIN.
  always_comb begin
    mul_overflow = (product[2*WIDTH-1:WIDTH] != {WIDTH{product[WIDTH-1]}});
    if (div_zero)
      div_result = '0;
    else if (sign_diff)
      div_result = -quotient;
    else
      div_result = quotient;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      data_resultRDY <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      sign_diff      <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
    end else if (start) begin
      state          <= ctrl_MULT ? MUL : DIV;
      busy           <= 1'b1;
      data_resultRDY <= 1'b0;
      sign_diff      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div_zero       <= (data_operandB == '0);
      div_ovf        <= (data_operandA == INT_MIN) && (data_operandB == NEG_ONE);
    end else begin
      case (state)
        MUL: begin
          if (iter_done) begin
            state          <= DONE;
            data_resultRDY <= 1'b1;
            data_result    <= product[WIDTH-1:0];
            data_exception <= mul_overflow;
          end
        end
        DIV: begin
          if (iter_done) begin
            state          <= DONE;
            data_resultRDY <= 1'b1;
            data_result    <= div_result;
            data_exception <= div_zero | div_ovf;
          end
        end
        DONE: begin
          state          <= IDLE;
          busy           <= 1'b0;
          data_resultRDY <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed corner cases plus randomized operations vs. an arithmetic model.
module tb_multdiv_unit;

  logic        clock;
  logic        reset_n;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checkCount = 0;
  int errorCount = 0;

  multdiv_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: plain signed arithmetic on 64-bit integers; multiply wins when both starts are high.
  task automatic refModel(input bit doMult, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic exc);
    longint p;
    int sa;
    int sb;
    int sq;
    if (doMult) begin
      p   = longint'(signed'(a)) * longint'(signed'(b));
      res = p[31:0];
      exc = (p != longint'(signed'(p[31:0])));
    end else if (b == 32'd0) begin
      res = 32'd0;
      exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      res = 32'h8000_0000;
      exc = 1'b1;
    end else begin
      sa  = signed'(a);
      sb  = signed'(b);
      sq  = sa / sb;
      res = sq;
      exc = 1'b0;
    end
  endtask

  task automatic startOp(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Called at the negedge after the start edge; expects RDY exactly 33 edges after it.
  task automatic waitResult(input string tag, input logic [31:0] expRes, input logic expExc);
    int cycles = 0;
    bit seen = 0;
    while (!seen && cycles < 100) begin
      @(posedge clock);
      #1;
      cycles++;
      if (data_resultRDY) seen = 1;
    end
    checkOutput({tag, "_latency"}, 64'(cycles), 64'd33);
    if (seen) begin
      checkOutput({tag, "_result"}, 64'(data_result), 64'(expRes));
      checkOutput({tag, "_exc"}, 64'(data_exception), 64'(expExc));
      @(posedge clock);
      #1;
      checkOutput({tag, "_rdy_pulse"}, 64'(data_resultRDY), 64'd0);
      checkOutput({tag, "_busy_after"}, 64'(busy), 64'd0);
      checkOutput({tag, "_hold"}, {31'd0, data_exception, data_result}, {31'd0, expExc, expRes});
    end
  endtask

  task automatic applyStimulus(input string tag, input bit m, input bit d,
                               input logic [31:0] a, input logic [31:0] b);
    logic [31:0] expRes;
    logic        expExc;
    refModel(m, a, b, expRes, expExc);
    startOp(m, d, a, b);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
    waitResult(tag, expRes, expExc);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd0;
      3:       return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int rdyCount;
    logic [31:0] a;
    logic [31:0] b;
    bit isMult;

    reset_n       = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    #12;
    checkOutput("reset_outputs", {30'd0, busy, data_resultRDY, data_exception, data_result}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    applyStimulus("mul_7x-6", 1, 0, 32'd7, 32'hFFFF_FFFA);
    applyStimulus("mul_ovf", 1, 0, 32'h0001_0000, 32'h0001_0000);

    // Reset in the middle of a multiply must clear everything at once and never produce RDY.
    startOp(1, 0, 32'd7, 32'd6);
    repeat (8) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("reset_mid_mul", {30'd0, busy, data_resultRDY, data_exception, data_result}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    rdyCount = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdyCount++;
    end
    checkOutput("reset_no_rdy", 64'(rdyCount), 64'd0);

    applyStimulus("mul_intmin_x1", 1, 0, 32'h8000_0000, 32'd1);
    applyStimulus("div_-7/2", 0, 1, 32'hFFFF_FFF9, 32'd2);
    applyStimulus("div_by_zero", 0, 1, 32'd100, 32'd0);
    applyStimulus("div_intmin/-1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF);

    // Abort: DIV sampled five edges after a MULT start replaces it.
    startOp(1, 0, 32'd3, 32'd3);
    repeat (3) @(negedge clock);
    startOp(0, 1, 32'd9, 32'd3);
    waitResult("abort_div", 32'd3, 1'b0);
    rdyCount = 0;
    repeat (10) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdyCount++;
    end
    checkOutput("abort_single_rdy", 64'(rdyCount), 64'd0);

    applyStimulus("both_start", 1, 1, 32'd8, 32'd2);

    for (int i = 0; i < 40; i++) begin
      a      = pickOperand();
      b      = pickOperand();
      isMult = 1'($urandom_range(0, 1));
      applyStimulus(isMult ? "rand_mul" : "rand_div", isMult, !isMult, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
